// File: rtl/packet_assembler.sv
// packet_assembler: gathers MSB-first nbits_in chunks into one registered nbits_out packet.
module packet_assembler #(
  parameter int nbits_in  = 8,
  parameter int nbits_out = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  input  logic [nbits_in-1:0]  recv_msg,
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [nbits_out-1:0] send_msg
);
  localparam int num_regs = (nbits_out + nbits_in - 1) / nbits_in;
  localparam int cnt_bits = num_regs > 1 ? $clog2(num_regs) : 1;
  logic [cnt_bits-1:0]  cnt;
  logic                 last;
  logic                 acc;
  logic [nbits_out-1:0] nxt;
  if (nbits_in > nbits_out) begin : g_bad
    $error("packet_assembler: nbits_in must not exceed nbits_out");
  end
  assign last     = cnt == cnt_bits'(num_regs - 1);
  assign recv_rdy = reset | ~send_val | send_rdy | ~last;
  assign acc      = recv_val & recv_rdy;
  if (num_regs == 1) begin : g_one
    assign nxt = recv_msg;
  end else begin : g_multi
    localparam int sw = nbits_out - nbits_in;
    // Shift chunks in from the bottom; bits of the first chunk beyond the packet width fall off the top.
    logic [sw-1:0] stage;
    always_ff @(posedge clk)
      if (reset) stage <= '0;
      else if (acc) stage <= sw'({stage, recv_msg});
    assign nxt = {stage, recv_msg};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      send_val <= 1'b0;
      send_msg <= '0;
    end else begin
      if (acc) cnt <= last ? '0 : cnt + cnt_bits'(1);
      if (acc && last) begin
        send_val <= 1'b1;
        send_msg <= nxt;
      end else if (send_rdy) send_val <= 1'b0;
    end
  end
endmodule

// File: tb/tb_packet_assembler.sv
// tb_packet_assembler: four width configurations, each checked every cycle against a queue-based model.
module tb_packet_assembler;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int total = 0, passes = 0;
  task automatic chk(input string nm, input int cfg, input longint got, input longint exp);
    total++;
    if (got == exp) passes++;
    else $display("FAIL %s cfg%0d: got %0h want %0h", nm, cfg, got, exp);
  endtask
  localparam int NO[4] = '{16, 12, 32, 8};
  localparam logic [7:0] CA[4][8] = '{
    '{8'hAB, 8'hCD, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'hFA, 8'hBC, 8'h01, 8'h23, 8'h00, 8'h00, 8'h00, 8'h00},
    '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08},
    '{8'h5A, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
  localparam logic [31:0] EA[4][2] = '{'{32'hABCD, 32'h1122}, '{32'hABC, 32'h123},
                                      '{32'h01020304, 32'h05060708}, '{32'h5A, 32'hC3}};
  localparam logic [31:0] EB[4][2] = '{'{32'h1122, 32'h3344}, '{32'h122, 32'h344},
                                      '{32'h11223344, 32'h55667788}, '{32'h11, 32'h22}};
  localparam logic [31:0] EC[4] = '{32'h1234, 32'h234, 32'h12345678, 32'h12};
  for (genvar c = 0; c < 4; c++) begin : g
    localparam int O = NO[c];
    localparam int R = (O + 7) / 8;
    logic reset = 1'b1, recv_val = 1'b0, send_rdy = 1'b0, recv_rdy, send_val;
    logic [7:0] recv_msg = 8'h00;
    logic [O-1:0] send_msg;
    logic done = 1'b0;
    packet_assembler #(.nbits_in(8), .nbits_out(O)) dut (
      .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
      .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg));
    logic [7:0] q[$];
    bit ov = 1'b0, armed = 1'b0, er;
    longint om = 0, pk;
    int cyc = 0, rdy_low = 0;
    longint got[$];
    int got_t[$];
    always @(negedge clk) begin
      er = reset || !ov || send_rdy || q.size() != R - 1;
      cyc++;
      if (armed) begin
        chk("recv_rdy", c, longint'(recv_rdy), longint'(er));
        chk("send_val", c, longint'(send_val), longint'(ov));
        chk("send_msg", c, longint'(send_msg), om);
      end
      if (send_val && send_rdy) begin
        got.push_back(longint'(send_msg));
        got_t.push_back(cyc);
      end
      if (!recv_rdy) rdy_low++;
      if (reset) begin
        q.delete();
        ov = 1'b0;
        om = 0;
        armed = 1'b1;
      end else if (recv_val && er && q.size() == R - 1) begin
        pk = 0;
        foreach (q[i]) pk = (pk << 8) | longint'(q[i]);
        om = ((pk << 8) | longint'(recv_msg)) & ((longint'(1) << O) - 1);
        ov = 1'b1;
        q.delete();
      end else begin
        if (ov && send_rdy) ov = 1'b0;
        if (recv_val && er) q.push_back(recv_msg);
      end
    end
    task automatic tick();
      @(posedge clk);
      #1;
    endtask
    task automatic put(input logic [7:0] v);
      recv_val = 1'b1;
      recv_msg = v;
      for (int n = 0; n < 50; n++) begin
        @(negedge clk);
        if (recv_rdy) begin
          tick();
          recv_val = 1'b0;
          return;
        end
        tick();
      end
      total++;
      $display("FAIL accept cfg%0d: chunk %0h not taken within 50 cycles", c, v);
      recv_val = 1'b0;
    endtask
    initial begin
      repeat (2) tick();
      chk("rst_val", c, longint'(send_val), 0);
      chk("rst_msg", c, longint'(send_msg), 0);
      chk("rst_rdy", c, longint'(recv_rdy), 1);
      reset = 1'b0;
      send_rdy = 1'b1;
      got.delete();
      got_t.delete();
      rdy_low = 0;
      for (int k = 0; k < 2 * R; k++) put(CA[c][k]);
      repeat (2) tick();
      chk("a_cnt", c, longint'(got.size()), 2);
      if (got.size() == 2) begin
        chk("a_pkt0", c, got[0], longint'(EA[c][0]));
        chk("a_pkt1", c, got[1], longint'(EA[c][1]));
        chk("a_gap", c, longint'(got_t[1] - got_t[0]), longint'(R));
      end
      chk("a_rdy_low", c, longint'(rdy_low), 0);
      send_rdy = 1'b0;
      for (int k = 0; k < 2 * R - 1; k++) put(8'(17 * (k + 1)));
      recv_val = 1'b1;
      recv_msg = 8'(17 * 2 * R);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("b_block", c, longint'(recv_rdy), 0);
        chk("b_hold", c, longint'(send_msg), longint'(EB[c][0]));
        chk("b_val", c, longint'(send_val), 1);
        tick();
      end
      send_rdy = 1'b1;
      @(negedge clk);
      chk("b_go", c, longint'(recv_rdy), 1);
      tick();
      send_rdy = 1'b0;
      recv_val = 1'b0;
      @(negedge clk);
      chk("b_next_val", c, longint'(send_val), 1);
      chk("b_next", c, longint'(send_msg), longint'(EB[c][1]));
      tick();
      send_rdy = 1'b1;
      tick();
      send_rdy = 1'b0;
      put(8'hAA);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("r_val", c, longint'(send_val), 0);
      chk("r_msg", c, longint'(send_msg), 0);
      tick();
      send_rdy = 1'b1;
      for (int k = 0; k < R; k++) put(8'(8'h12 + 8'h22 * k));
      @(negedge clk);
      chk("r_val2", c, longint'(send_val), 1);
      chk("r_pkt", c, longint'(send_msg), longint'(EC[c]));
      tick();
      for (int n = 0; n < 400; n++) begin
        recv_val = $urandom_range(3) != 0;
        recv_msg = 8'($urandom);
        send_rdy = $urandom_range(2) != 0;
        reset = $urandom_range(63) == 0;
        tick();
      end
      reset = 1'b0;
      recv_val = 1'b0;
      tick();
      done = 1'b1;
    end
  end
  initial begin
    for (int n = 0; n < 20000 && !(g[0].done && g[1].done && g[2].done && g[3].done); n++)
      @(posedge clk);
    if (!(g[0].done && g[1].done && g[2].done && g[3].done)) begin
      total++;
      $display("FAIL timeout: stimulus did not complete within 20000 cycles");
    end
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
